bitwise_response_checker: RTL and testbench

- Sequential self-checking monitor for the bitwise operator unit. It sits on the unit's operand and result buses in simulation and in FPGA bring-up.
- Each valid cycle it computes the golden results from a, b and c, compares them against the seven unit outputs, and counts mismatches.
- It records the first failing vector and reports pass/fail once a programmed number of vectors has been checked.

---
 rtl/bitwise_response_checker.sv | 143 ++++++++++++++
 tb/tb_bitwise_response_checker.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bitwise_response_checker.sv
// bitwise_response_checker
//   Monitor for the bitwise operator unit. Every accepted vector is compared
//   against the golden results (u=a&b, v=a|b, w=a^b, x=~a, y=~(a&b),
//   z=~(a|b), s=a^b^c). Mismatching vectors are counted, and the first one
//   is captured. Pass/fail is reported once num_vec vectors have been checked.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start, num_vec    arm a run of num_vec vectors (accepted in IDLE/DONE)
//   vec_valid         a/b/c and u..s are valid this cycle
//   a, b, c           operands presented to the unit
//   u..s              unit results under test
//   busy, done, pass  run status; pass is meaningful only while done=1
//   err_count         failing vectors this run, saturating
//   vec_count         vectors accepted this run
//   first_fail_idx    index of the first failing vector
//   first_fail_mask   per-output mismatch of that vector, bit6=u .. bit0=s
module bitwise_response_checker #(
  parameter int W  = 4,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] num_vec,
  input  logic          vec_valid,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [W-1:0]  c,
  input  logic [W-1:0]  u,
  input  logic [W-1:0]  v,
  input  logic [W-1:0]  w,
  input  logic [W-1:0]  x,
  input  logic [W-1:0]  y,
  input  logic [W-1:0]  z,
  input  logic [W-1:0]  s,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [CW-1:0] err_count,
  output logic [CW-1:0] vec_count,
  output logic [CW-1:0] first_fail_idx,
  output logic [6:0]    first_fail_mask
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  state_t        state, state_nxt;
  logic [CW-1:0] num_lat;
  logic          arm;
  logic          accept;
  logic          last_vec;

  logic          vld_p0;
  logic [6:0]    mask_p0;
  logic [CW-1:0] idx_p0;

  function automatic logic [6:0] golden_mismatch(
    input logic [W-1:0] ai, input logic [W-1:0] bi, input logic [W-1:0] ci,
    input logic [W-1:0] ui, input logic [W-1:0] vi, input logic [W-1:0] wi,
    input logic [W-1:0] xi, input logic [W-1:0] yi, input logic [W-1:0] zi,
    input logic [W-1:0] si);
    golden_mismatch = {ui != (ai & bi),
                       vi != (ai | bi),
                       wi != (ai ^ bi),
                       xi != ~ai,
                       yi != ~(ai & bi),
                       zi != ~(ai | bi),
                       si != (ai ^ bi ^ ci)};
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] val);
    sat_inc = (val == {CW{1'b1}}) ? val : val + ONE;
  endfunction

  // start is only honoured between runs; vec_valid only while running.
  assign arm      = start && ((state == IDLE) || (state == DONE));
  assign accept   = vec_valid && (state == RUN);
  assign last_vec = accept && ((vec_count + ONE) == num_lat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (arm) state_nxt = (num_vec == '0) ? DONE : RUN;
      RUN:        if (last_vec) state_nxt = DRAIN;
      DRAIN:      state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN) || (state == DRAIN);
    done = (state == DONE);
    pass = (state == DONE) && (err_count == '0);
  end

  // ---- stage p0: register per-output mismatch and index of accepted vector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p0 <= 1'b0;
    else        vld_p0 <= accept;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mask_p0 <= golden_mismatch(a, b, c, u, v, w, x, y, z, s);
      idx_p0  <= vec_count;
    end
  end

  // ---- stage p1: accumulate errors and capture the first failure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_lat         <= '0;
      vec_count       <= '0;
      err_count       <= '0;
      first_fail_idx  <= '0;
      first_fail_mask <= '0;
    end else if (arm) begin
      num_lat         <= num_vec;
      vec_count       <= '0;
      err_count       <= '0;
      first_fail_idx  <= '0;
      first_fail_mask <= '0;
    end else begin
      if (accept) vec_count <= vec_count + ONE;
      if (vld_p0 && (mask_p0 != 7'd0)) begin
        err_count <= sat_inc(err_count);
        if (err_count == '0) begin
          first_fail_idx  <= idx_p0;
          first_fail_mask <= mask_p0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bitwise_response_checker.sv
module tb_bitwise_response_checker;
  localparam int W   = 4;
  localparam int CW  = 16;
  localparam int CW2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, start, start2, vec_valid;
  logic [CW-1:0]  num_vec;
  logic [CW2-1:0] num_vec2;
  logic [W-1:0]   a, b, c, u, v, w, x, y, z, s;

  logic           busy, done, pass;
  logic [CW-1:0]  err_count, vec_count, first_fail_idx;
  logic [6:0]     first_fail_mask;
  logic           busy2, done2, pass2;
  logic [CW2-1:0] err_count2, vec_count2, first_fail_idx2;
  logic [6:0]     first_fail_mask2;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] va[32], vb[32], vc[32];
  logic [W-1:0] ru[32], rv[32], rw[32], rx[32], ry[32], rz[32], rs[32];

  bitwise_response_checker #(.W(W), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vec(num_vec), .vec_valid(vec_valid),
    .a(a), .b(b), .c(c), .u(u), .v(v), .w(w), .x(x), .y(y), .z(z), .s(s),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .vec_count(vec_count),
    .first_fail_idx(first_fail_idx), .first_fail_mask(first_fail_mask));

  bitwise_response_checker #(.W(W), .CW(CW2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .num_vec(num_vec2), .vec_valid(vec_valid),
    .a(a), .b(b), .c(c), .u(u), .v(v), .w(w), .x(x), .y(y), .z(z), .s(s),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2), .vec_count(vec_count2),
    .first_fail_idx(first_fail_idx2), .first_fail_mask(first_fail_mask2));

  // Store a vector with correct unit results.
  task automatic set_vec(input int i, input logic [W-1:0] ai, input logic [W-1:0] bi, input logic [W-1:0] ci);
    va[i] = ai; vb[i] = bi; vc[i] = ci;
    ru[i] = ai & bi;    rv[i] = ai | bi;    rw[i] = ai ^ bi; rx[i] = ~ai;
    ry[i] = ~(ai & bi); rz[i] = ~(ai | bi); rs[i] = ai ^ bi ^ ci;
  endtask

  // Flip bits of one result; k=6 is u down to k=0 is s.
  task automatic corrupt(input int i, input int k, input logic [W-1:0] pat);
    case (k)
      6: ru[i] = ru[i] ^ pat;
      5: rv[i] = rv[i] ^ pat;
      4: rw[i] = rw[i] ^ pat;
      3: rx[i] = rx[i] ^ pat;
      2: ry[i] = ry[i] ^ pat;
      1: rz[i] = rz[i] ^ pat;
      default: rs[i] = rs[i] ^ pat;
    endcase
  endtask

  task automatic rand_vec(input int i, input int pct);
    set_vec(i, W'($urandom), W'($urandom), W'($urandom));
    for (int k = 0; k < 7; k++)
      if ($urandom_range(0, 99) < pct) corrupt(i, k, W'($urandom_range(1, 15)));
  endtask

  // Reference: which vectors are wrong, how many (saturating), first one.
  task automatic model(input int n, input int cw, output int err, output int idx, output logic [6:0] mask);
    logic [6:0] m;
    int maxv;
    maxv = (1 << cw) - 1;
    err = 0; idx = 0; mask = 7'd0;
    for (int i = 0; i < n; i++) begin
      m = {ru[i] != (va[i] & vb[i]), rv[i] != (va[i] | vb[i]), rw[i] != (va[i] ^ vb[i]),
           rx[i] != ~va[i], ry[i] != ~(va[i] & vb[i]), rz[i] != ~(va[i] | vb[i]),
           rs[i] != (va[i] ^ vb[i] ^ vc[i])};
      if (m != 7'd0) begin
        if (err == 0) begin idx = i; mask = m; end
        if (err < maxv) err++;
      end
    end
  endtask

  task automatic put_vec(input int i);
    a = va[i]; b = vb[i]; c = vc[i];
    u = ru[i]; v = rv[i]; w = rw[i]; x = rx[i]; y = ry[i]; z = rz[i]; s = rs[i];
  endtask

  task automatic put_garbage();
    a = W'($urandom); b = W'($urandom); c = W'($urandom);
    u = W'($urandom); v = W'($urandom); w = W'($urandom); x = W'($urandom);
    y = W'($urandom); z = W'($urandom); s = W'($urandom);
  endtask

  // Arm a run on dut (sel=0) or dut2 (sel=1) and present n stored vectors.
  // Returns at the falling edge after the edge that took the last vector.
  task automatic drive_run(input int n, input bit gaps, input bit sel);
    @(negedge clk);
    if (sel) begin start2 = 1'b1; num_vec2 = CW2'(n); end
    else begin start = 1'b1; num_vec = CW'(n); end
    @(negedge clk);
    start = 1'b0; start2 = 1'b0;
    num_vec = CW'($urandom); num_vec2 = CW2'($urandom);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        vec_valid = 1'b0; put_garbage(); @(negedge clk);
      end
      vec_valid = 1'b1; put_vec(i);
      @(negedge clk);
      vec_valid = 1'b0; put_garbage();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; vec_valid = 1'b0;
    num_vec = '0; num_vec2 = '0; put_garbage();
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass got %b want 0", pass); end
    checks++; if ({err_count, vec_count, first_fail_idx} !== '0) begin errors++; $display("FAIL reset_counters got %h %h %h want 0", err_count, vec_count, first_fail_idx); end
    checks++; if (first_fail_mask !== 7'd0) begin errors++; $display("FAIL reset_mask got %b want 0", first_fail_mask); end
    rst_n = 1'b1;
  endtask

  task automatic test_directed_pass();
    set_vec(0, 4'b1000, 4'b1100, 4'b0000);
    set_vec(1, 4'b0000, 4'b1010, 4'b0100);
    set_vec(2, 4'b0010, 4'b1010, 4'b0011);
    checks++; if ({ru[0], rv[0], rw[0], rx[0], ry[0], rz[0], rs[0]} !== 28'h8C47734) begin errors++; $display("FAIL pass_golden0 got %h want 8c47734", {ru[0], rv[0], rw[0], rx[0], ry[0], rz[0], rs[0]}); end
    drive_run(3, 1'b0, 1'b0);
    checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL pass_drain busy/done got %b want 10", {busy, done}); end
    @(negedge clk);
    checks++; if ({busy, done, pass} !== 3'b011) begin errors++; $display("FAIL pass_done busy/done/pass got %b want 011", {busy, done, pass}); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL pass_err got %0d want 0", err_count); end
    checks++; if (vec_count !== 16'd3) begin errors++; $display("FAIL pass_vec got %0d want 3", vec_count); end
  endtask

  task automatic test_single_fail();
    rv[1] = 4'b1111;
    drive_run(3, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if ({done, pass} !== 2'b10) begin errors++; $display("FAIL single_done_pass got %b want 10", {done, pass}); end
    checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL single_err got %0d want 1", err_count); end
    checks++; if (first_fail_idx !== 16'd1) begin errors++; $display("FAIL single_idx got %0d want 1", first_fail_idx); end
    checks++; if (first_fail_mask !== 7'b0100000) begin errors++; $display("FAIL single_mask got %b want 0100000", first_fail_mask); end
  endtask

  task automatic test_multi_fail();
    for (int i = 0; i < 4; i++) rand_vec(i, 0);
    corrupt(1, 6, W'($urandom_range(1, 15)));
    corrupt(1, 0, W'($urandom_range(1, 15)));
    corrupt(3, 1, W'($urandom_range(1, 15)));
    drive_run(4, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (err_count !== 16'd2) begin errors++; $display("FAIL multi_err got %0d want 2", err_count); end
    checks++; if (first_fail_idx !== 16'd1) begin errors++; $display("FAIL multi_idx got %0d want 1", first_fail_idx); end
    checks++; if (first_fail_mask !== 7'b1000001) begin errors++; $display("FAIL multi_mask got %b want 1000001", first_fail_mask); end
    checks++; if ({done, pass} !== 2'b10) begin errors++; $display("FAIL multi_done_pass got %b want 10", {done, pass}); end
  endtask

  task automatic test_zero_vec();
    int busy_seen;
    busy_seen = 0;
    @(negedge clk); start = 1'b1; num_vec = '0;
    @(negedge clk); start = 1'b0;
    busy_seen += int'(busy);
    checks++; if ({done, pass} !== 2'b11) begin errors++; $display("FAIL zero_done_pass got %b want 11", {done, pass}); end
    vec_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin put_garbage(); @(negedge clk); busy_seen += int'(busy); end
    vec_valid = 1'b0;
    checks++; if (busy_seen != 0) begin errors++; $display("FAIL zero_busy got %0d busy cycles want 0", busy_seen); end
    checks++; if (vec_count !== 16'd0) begin errors++; $display("FAIL zero_vec got %0d want 0", vec_count); end
    checks++; if ({done, pass, err_count} !== {2'b11, 16'd0}) begin errors++; $display("FAIL zero_hold got %b %0d want 11 0", {done, pass}, err_count); end
  endtask

  task automatic test_gaps_reset();
    int e_err, e_idx;
    logic [6:0] e_mask;
    rand_vec(0, 0); corrupt(0, 4, W'($urandom_range(1, 15)));
    rand_vec(1, 0);
    @(negedge clk); start = 1'b1; num_vec = 16'd5;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vec_valid = 1'b0; put_garbage(); repeat (2) @(negedge clk);
      vec_valid = 1'b1; put_vec(i); @(negedge clk);
    end
    vec_valid = 1'b0;
    start = 1'b1; num_vec = 16'd1;
    @(negedge clk); start = 1'b0;
    checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL midrun_start busy/done got %b want 10", {busy, done}); end
    checks++; if (vec_count !== 16'd2) begin errors++; $display("FAIL midrun_vec got %0d want 2", vec_count); end
    checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL midrun_err got %0d want 1", err_count); end
    rst_n = 1'b0;
    #1;
    checks++; if ({busy, done, pass} !== 3'b000) begin errors++; $display("FAIL abort_status got %b want 000", {busy, done, pass}); end
    checks++; if ({err_count, vec_count, first_fail_idx, first_fail_mask} !== '0) begin errors++; $display("FAIL abort_regs got %h %h %h %b want 0", err_count, vec_count, first_fail_idx, first_fail_mask); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL abort_idle got %b want 00", {busy, done}); end
    for (int i = 0; i < 5; i++) rand_vec(i, 20);
    drive_run(5, 1'b1, 1'b0);
    @(negedge clk);
    model(5, CW, e_err, e_idx, e_mask);
    checks++; if ({done, vec_count} !== {1'b1, 16'd5}) begin errors++; $display("FAIL fresh_done_vec got %b %0d want 1 5", done, vec_count); end
    checks++; if (err_count !== CW'(e_err)) begin errors++; $display("FAIL fresh_err got %0d want %0d", err_count, e_err); end
    checks++; if ({first_fail_idx, first_fail_mask} !== {CW'(e_idx), e_mask}) begin errors++; $display("FAIL fresh_first got %0d %b want %0d %b", first_fail_idx, first_fail_mask, e_idx, e_mask); end
  endtask

  task automatic test_random();
    int n, e_err, e_idx;
    logic [6:0] e_mask;
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 14);
      for (int i = 0; i < n; i++) rand_vec(i, (r % 2 == 0) ? 3 : 12);
      model(n, CW, e_err, e_idx, e_mask);
      drive_run(n, 1'b1, 1'b0);
      checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL rand%0d_drain got %b want 10", r, {busy, done}); end
      @(negedge clk);
      checks++; if ({done, pass} !== {1'b1, e_err == 0}) begin errors++; $display("FAIL rand%0d_done_pass got %b want 1%b", r, {done, pass}, e_err == 0); end
      checks++; if ({err_count, vec_count} !== {CW'(e_err), CW'(n)}) begin errors++; $display("FAIL rand%0d_counts got %0d %0d want %0d %0d", r, err_count, vec_count, e_err, n); end
      checks++; if ({first_fail_idx, first_fail_mask} !== {CW'(e_idx), e_mask}) begin errors++; $display("FAIL rand%0d_first got %0d %b want %0d %b", r, first_fail_idx, first_fail_mask, e_idx, e_mask); end
    end
  endtask

  task automatic test_saturate();
    int e_err, e_idx;
    logic [6:0] e_mask;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) begin
        rand_vec(i, 0);
        for (int k = 0; k < 7; k++) corrupt(i, k, W'($urandom_range(1, 15)));
      end
      model(3, CW2, e_err, e_idx, e_mask);
      drive_run(3, r == 1, 1'b1);
      @(negedge clk);
      checks++; if ({done2, pass2} !== 2'b10) begin errors++; $display("FAIL sat%0d_done_pass got %b want 10", r, {done2, pass2}); end
      checks++; if (err_count2 !== 2'd3 || err_count2 !== CW2'(e_err)) begin errors++; $display("FAIL sat%0d_err got %0d want 3 (model %0d)", r, err_count2, e_err); end
      checks++; if ({vec_count2, first_fail_idx2, first_fail_mask2} !== {2'd3, 2'd0, 7'h7f}) begin errors++; $display("FAIL sat%0d_vec_first got %0d %0d %b want 3 0 1111111", r, vec_count2, first_fail_idx2, first_fail_mask2); end
    end
  endtask

  initial begin
    test_reset();
    test_directed_pass();
    test_single_fail();
    test_multi_fail();
    test_zero_vec();
    test_gaps_reset();
    test_random();
    test_saturate();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
